// File: rtl/clk_div_scheduler.sv
// Glitch-free start/stop sequencer for a programmable clock divider; all outputs registered (one edge).
// A config offer stalls (cfg_ready=0) while one is pending in RUN or while STOPPING drains.
module clk_div_scheduler #(
  parameter int CNT_W       = 6,
  parameter int DEFAULT_DIV = 49
) (
  input  logic             Clck_in,
  input  logic             reset_Clock,
  input  logic             run_en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [7:0]       cfg_burst,
  output logic             cfg_ready,
  output logic             Clock_out,
  output logic             tick,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, r_div, r_pend_div;
  logic [7:0]       r_burst, r_pend_burst, r_period;
  logic             r_pend, r_clk, r_tick, r_done, r_cfg_ready, r_busy;

  logic             w_accept, w_term, w_burst_end;
  logic [CNT_W-1:0] w_idle_div;
  logic [7:0]       w_idle_burst;

  always_comb begin
    w_accept     = cfg_valid & r_cfg_ready;
    w_term       = (r_cnt == r_div);
    // A falling toggle that completes the burst; a pending config restarts the count instead.
    w_burst_end  = r_clk && (r_burst != 8'd0) && ((r_period + 8'd1) == r_burst) && !r_pend;
    w_idle_div   = w_accept ? cfg_div   : (r_pend ? r_pend_div   : r_div);
    w_idle_burst = w_accept ? cfg_burst : (r_pend ? r_pend_burst : r_burst);
  end

  always_ff @(posedge Clck_in) begin
    if (reset_Clock) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_div        <= DIV_RST;
      r_burst      <= 8'd0;
      r_pend_div   <= '0;
      r_pend_burst <= 8'd0;
      r_period     <= 8'd0;
      r_pend       <= 1'b0;
      r_clk        <= 1'b0;
      r_tick       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt       <= '0;
          r_clk       <= 1'b0;
          r_period    <= 8'd0;
          r_cfg_ready <= 1'b1;
          if (w_accept) begin
            r_div   <= cfg_div;
            r_burst <= cfg_burst;
          end
          if (run_en) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end

        RUN: begin
          if ((!run_en && (!r_clk || w_term)) || (w_term && w_burst_end)) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cfg_ready <= 1'b1;
            r_cnt       <= '0;
            r_period    <= 8'd0;
            r_div       <= w_idle_div;
            r_burst     <= w_idle_burst;
            r_pend      <= 1'b0;
            if (r_clk) begin
              r_clk  <= 1'b0;
              r_tick <= 1'b1;
            end
          end else if (w_term) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            r_tick <= 1'b1;
            if (r_pend) begin
              r_div       <= r_pend_div;
              r_burst     <= r_pend_burst;
              r_period    <= 8'd0;
              r_pend      <= 1'b0;
              r_cfg_ready <= 1'b1;
            end else begin
              if (r_clk && (r_burst != 8'd0)) r_period <= r_period + 8'd1;
              if (w_accept) begin
                r_pend       <= 1'b1;
                r_pend_div   <= cfg_div;
                r_pend_burst <= cfg_burst;
                r_cfg_ready  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_accept) begin
              r_pend       <= 1'b1;
              r_pend_div   <= cfg_div;
              r_pend_burst <= cfg_burst;
              r_cfg_ready  <= 1'b0;
            end
            // High phase must finish before the clock can be parked low.
            if (!run_en) begin
              r_state     <= STOPPING;
              r_cfg_ready <= 1'b0;
            end
          end
        end

        STOPPING: begin
          if (w_term) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_tick      <= 1'b1;
            r_clk       <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_cnt       <= '0;
            r_period    <= 8'd0;
            r_div       <= w_idle_div;
            r_burst     <= w_idle_burst;
            r_pend      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign Clock_out = r_clk;
  assign tick      = r_tick;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Directed bench for clk_div_scheduler: half-period lengths, bursts, config timing, stop and reset.
module tb_clk_div_scheduler;

  logic       Clck_in = 1'b0;
  logic       reset_Clock;
  logic       run_en;
  logic       cfg_valid;
  logic [5:0] cfg_div;
  logic [7:0] cfg_burst;
  logic       cfg_ready, Clock_out, tick, done, busy;

  int checks   = 0;
  int failures = 0;
  int n;

  clk_div_scheduler #(.CNT_W(6), .DEFAULT_DIV(49)) dut (
    .Clck_in    (Clck_in),
    .reset_Clock(reset_Clock),
    .run_en     (run_en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_burst  (cfg_burst),
    .cfg_ready  (cfg_ready),
    .Clock_out  (Clock_out),
    .tick       (tick),
    .done       (done),
    .busy       (busy)
  );

  always #5 Clck_in = ~Clck_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge Clck_in);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles until Clock_out changes; capped so a stuck output still ends the run.
  task automatic wait_toggle(output int cnt);
    logic prev;
    prev = Clock_out;
    cnt  = 0;
    do begin
      cyc();
      cnt++;
    end while (Clock_out === prev && cnt < 200);
  endtask

  initial begin
    reset_Clock = 1'b1;
    run_en      = 1'b0;
    cfg_valid   = 1'b0;
    cfg_div     = 6'd0;
    cfg_burst   = 8'd0;
    cyc();
    cyc();
    chk1("rst_clk", Clock_out, 1'b0);
    chk1("rst_tick", tick, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ready", cfg_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);

    // Default divide: 50-cycle half-periods
    reset_Clock = 1'b0;
    run_en      = 1'b1;
    cyc();
    chk1("run_busy", busy, 1'b1);
    chk1("run_clk0", Clock_out, 1'b0);
    wait_toggle(n);
    chkn("def_rise", n, 50);
    chk1("def_rise_tick", tick, 1'b1);
    chk1("def_rise_lvl", Clock_out, 1'b1);
    wait_toggle(n);
    chkn("def_fall", n, 50);
    chk1("def_ready", cfg_ready, 1'b1);

    // Stop with Clock_out low: immediate IDLE, no tick
    run_en = 1'b0;
    cyc();
    chk1("stop0_done", done, 1'b1);
    chk1("stop0_tick", tick, 1'b0);
    chk1("stop0_busy", busy, 1'b0);
    chk1("stop0_clk", Clock_out, 1'b0);

    // Burst of 2 periods at div 3, config and run together
    cfg_valid = 1'b1;
    cfg_div   = 6'd3;
    cfg_burst = 8'd2;
    run_en    = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    cfg_burst = 8'd0;
    chk1("burst_busy", busy, 1'b1);
    wait_toggle(n); chkn("burst_h1", n, 4);
    wait_toggle(n); chkn("burst_h2", n, 4);
    chk1("burst_mid_done", done, 1'b0);
    wait_toggle(n); chkn("burst_h3", n, 4);
    wait_toggle(n); chkn("burst_h4", n, 4);
    chk1("burst_done", done, 1'b1);
    chk1("burst_idle", busy, 1'b0);
    chk1("burst_clk", Clock_out, 1'b0);
    run_en = 1'b0;
    cyc();
    chk1("burst_done_pulse", done, 1'b0);
    chk1("burst_stay_idle", busy, 1'b0);

    // Div 9, change to div 1 in the middle of a half-period
    cfg_valid = 1'b1;
    cfg_div   = 6'd9;
    run_en    = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk1("mid_ready_pre", cfg_ready, 1'b1);
    cfg_valid = 1'b1;
    cfg_div   = 6'd1;
    cyc();
    cfg_valid = 1'b0;
    chk1("mid_ready_busy", cfg_ready, 1'b0);
    wait_toggle(n); chkn("mid_old_half", n, 6);
    chk1("mid_ready_back", cfg_ready, 1'b1);
    wait_toggle(n); chkn("mid_new_half1", n, 2);
    wait_toggle(n); chkn("mid_new_half2", n, 2);

    // Accept exactly on the terminal cycle (div 1, counter at 1)
    cyc();
    cfg_valid = 1'b1;
    cfg_div   = 6'd4;
    cyc();
    cfg_valid = 1'b0;
    chk1("term_toggle", Clock_out, 1'b0);
    chk1("term_tick", tick, 1'b1);
    chk1("term_ready", cfg_ready, 1'b0);
    wait_toggle(n); chkn("term_old_half", n, 2);
    chk1("term_ready_back", cfg_ready, 1'b1);
    wait_toggle(n); chkn("term_new_half1", n, 5);
    wait_toggle(n); chkn("term_new_half2", n, 5);

    // Back to div 9, then drop run_en while high at counter 2
    cfg_valid = 1'b1;
    cfg_div   = 6'd9;
    cyc();
    cfg_valid = 1'b0;
    wait_toggle(n); chkn("d9_apply_half", n, 4);
    wait_toggle(n); chkn("d9_half", n, 10);
    chk1("d9_high", Clock_out, 1'b1);
    cyc(); cyc();
    run_en = 1'b0;
    cyc();
    chk1("stopping_busy", busy, 1'b1);
    chk1("stopping_clk", Clock_out, 1'b1);
    chk1("stopping_ready", cfg_ready, 1'b0);
    wait_toggle(n); chkn("stopping_rest", n, 7);
    chk1("stopping_done", done, 1'b1);
    chk1("stopping_tick", tick, 1'b1);
    chk1("stopping_idle", busy, 1'b0);
    chk1("stopping_clk0", Clock_out, 1'b0);

    // Reset while STOPPING with a pending config
    cfg_valid = 1'b1;
    cfg_div   = 6'd9;
    run_en    = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    wait_toggle(n); chkn("rs_half", n, 10);
    cfg_valid = 1'b1;
    cfg_div   = 6'd2;
    cyc();
    cfg_valid = 1'b0;
    chk1("rs_pending", cfg_ready, 1'b0);
    run_en = 1'b0;
    cyc();
    chk1("rs_stopping", busy, 1'b1);
    reset_Clock = 1'b1;
    cyc();
    chk1("rs_clk", Clock_out, 1'b0);
    chk1("rs_tick", tick, 1'b0);
    chk1("rs_done", done, 1'b0);
    chk1("rs_ready", cfg_ready, 1'b1);
    chk1("rs_busy", busy, 1'b0);
    reset_Clock = 1'b0;
    run_en      = 1'b1;
    cyc();
    wait_toggle(n); chkn("rs_default_div", n, 50);
    run_en = 1'b0;
    wait_toggle(n); chkn("rs_stop_high", n, 50);
    chk1("rs_stop_done", done, 1'b1);
    chk1("rs_stop_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_scheduler.md
Name: clk_div_scheduler

Overview:
- Run-time controller for the programmable clock divider used across the design.
- Sequences start and stop of the divided clock without glitches.
- Accepts new divide ratios over a valid/ready handshake and applies them only at a half-period boundary.
- Supports continuous running or bursts of N full output periods; sits between the control logic and any consumer of the divided clock or tick.

Parameters:
- CNT_W, 6, width of the half-period counter and of the divide value.
- DEFAULT_DIV, 49, divide value loaded at reset (half-period = DEFAULT_DIV+1 input cycles).

Ports:
- Clck_in  input  1  system clock; all logic on rising edge.
- reset_Clock  input  1  synchronous, active-high reset.
- run_en  input  1  level; 1 = run the divided clock, 0 = request stop.
- cfg_valid  input  1  configuration offer.
- cfg_div  input  CNT_W  new divide value (half-period = cfg_div+1 cycles).
- cfg_burst  input  8  number of full output periods; 0 = continuous.
- cfg_ready  output  1  controller can accept a configuration.
- Clock_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in the cycle Clock_out toggles.
- done  output  1  one-cycle pulse on return to IDLE from an active state.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, Clock_out 0, tick 0, done 0, cfg_ready 1, busy 0. Internally: counter 0, div_reg DEFAULT_DIV, burst_reg 0, period count 0, pending empty.
- States: IDLE, RUN, STOPPING.
- Counter: counts 0..div_reg. Terminal condition is counter == div_reg. On terminal, next edge sets counter to 0, toggles Clock_out and pulses tick. Otherwise counter +1.
- div_reg = 0 toggles Clock_out every cycle. The counter never exceeds div_reg because compare and wrap are exact.
- IDLE:
  - Counter held at 0, Clock_out 0.
  - cfg_ready = 1; on accept (cfg_valid & cfg_ready), div_reg/burst_reg load at the next edge.
  - run_en = 1 moves to RUN at the next edge; counter starts at 0.
  - If run_en and cfg accept occur in the same cycle, RUN uses the new values.
- RUN:
  - Free-running divide.
  - cfg_ready = 1 only while no config is pending. An accept stores cfg_div/cfg_burst as pending.
  - Pending values load into div_reg/burst_reg in the edge that completes the next terminal count; that terminal uses the old div_reg. The period count clears at the same time, and pending empties.
  - An accept in the same cycle as a terminal goes to pending and applies at the following terminal, not the current one.
- Burst:
  - When burst_reg != 0, the period count increments on each high-to-low toggle of Clock_out.
  - The toggle that makes count == burst_reg goes to IDLE and pulses done in the same edge. Clock_out ends at 0.
- Stop:
  - run_en = 0 in RUN with Clock_out 0: go to IDLE at the next edge; done pulses, no toggle.
  - run_en = 0 in RUN with Clock_out 1: go to STOPPING.
- STOPPING:
  - Continue counting. At terminal: Clock_out to 0, tick, done, then IDLE.
  - run_en returning to 1 in STOPPING is ignored until IDLE. A pending config still applies at that terminal. cfg_ready = 0.
- Output timing: no output is ever truncated mid-half-period except by reset. High phase is always div_reg+1 cycles.
- Reset mid-operation: everything returns to reset values in the next edge and pending is discarded, regardless of state.
- Output latency: all outputs registered. tick and done are coincident with the edge that changes Clock_out or state.

Test Plan:
- Reset, run_en=1, no config -> first Clock_out rise at cycle 50 after RUN entry, toggles every 50 cycles, tick each toggle, cfg_ready=1.
- In IDLE accept cfg_div=3, cfg_burst=2, run_en=1 same cycle -> 4-cycle half-periods, exactly 2 full periods (16 cycles), then done pulse, Clock_out 0, busy 0.
- RUN with div 9, accept cfg_div=1 mid half-period -> cfg_ready drops; current half-period stays 10 cycles; subsequent half-periods 2 cycles; cfg_ready returns 1 after apply.
- Accept config exactly on terminal cycle -> new div takes effect one half-period later; verify counter never exceeds div_reg.
- Drop run_en while Clock_out=1 at counter 2 of div 9 -> STOPPING for the remaining 8 cycles, then Clock_out 0, tick+done, IDLE. Same with Clock_out=0 -> IDLE next edge, no tick.
- Assert reset_Clock during STOPPING with pending config -> next edge all outputs at reset values; re-run shows div_reg = 49.
